// File: rtl/hexd_scan_if.sv
// Hex-display write port as driven by the MMIO crossbar.
// The crossbar side is the master. The display scanner is the slave.
interface hexd_scan_if;
    logic [15:0] i_data;
    logic        i_wren;

    modport master (output i_data, output i_wren);
    modport slave  (input  i_data, input  i_wren);
endinterface

// File: rtl/hexd_scan.sv
// Holds the last 16-bit value written by the crossbar.
// Scans it as four hex digits onto a multiplexed, active-low seven-segment display.
module hexd_scan #(
    parameter int CNT_W = 16,
    parameter int LZB   = 0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    hexd_scan_if.slave       bus,
    output logic [6:0]       o_segs,
    output logic [3:0]       o_anodes
);

    logic [CNT_W-1:0] cnt;
    logic [15:0]      data_q;
    logic [1:0]       sel;
    logic             dead;
    logic [3:0]       nib;
    logic             upper_zero;
    logic [6:0]       seg_next;
    logic [3:0]       an_next;

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        s = 7'h7F;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    assign sel  = cnt[CNT_W-1:CNT_W-2];
    assign dead = (cnt[CNT_W-3:0] == '0);

    // Nibble for the active digit, and whether every digit above it is zero.
    always_comb begin
        nib        = data_q[3:0];
        upper_zero = 1'b0;
        case (sel)
            2'd0: begin
                nib        = data_q[3:0];
                upper_zero = 1'b0;
            end
            2'd1: begin
                nib        = data_q[7:4];
                upper_zero = (data_q[15:4] == 12'h000);
            end
            2'd2: begin
                nib        = data_q[11:8];
                upper_zero = (data_q[15:8] == 8'h00);
            end
            2'd3: begin
                nib        = data_q[15:12];
                upper_zero = (data_q[15:12] == 4'h0);
            end
            default: begin
                nib        = data_q[3:0];
                upper_zero = 1'b0;
            end
        endcase
    end

    // The first cycle of each slot is dark so the previous digit does not ghost.
    always_comb begin
        seg_next = 7'h7F;
        an_next  = 4'b1111;
        if (!dead) begin
            an_next = ~(4'b0001 << sel);
            if ((LZB != 0) && upper_zero)
                seg_next = 7'h7F;
            else
                seg_next = decode(nib);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt      <= '0;
            data_q   <= 16'h0000;
            o_anodes <= 4'b1111;
            o_segs   <= 7'h7F;
        end else begin
            cnt      <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            if (bus.i_wren)
                data_q <= bus.i_data;
            o_anodes <= an_next;
            o_segs   <= seg_next;
        end
    end

endmodule

// File: tb/tb_hexd_scan.sv
// Directed bench for hexd_scan with CNT_W=4 (4-cycle slots, 16-cycle period).
// Two instances share one write port: one with LZB=0 and one with LZB=1.
module tb_hexd_scan;

    logic       i_clk;
    logic       i_rst;
    logic [6:0] segs0, segs1;
    logic [3:0] anodes0, anodes1;

    int vec_count;
    int miss_count;

    logic [3:0]  cnt_m;
    logic [15:0] data_m;

    hexd_scan_if bus();

    hexd_scan #(.CNT_W(4), .LZB(0)) dut0 (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .bus      (bus.slave),
        .o_segs   (segs0),
        .o_anodes (anodes0)
    );

    hexd_scan #(.CNT_W(4), .LZB(1)) dut1 (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .bus      (bus.slave),
        .o_segs   (segs1),
        .o_anodes (anodes1)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vec_count++;
        if (obs !== exp) begin
            miss_count++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        logic [6:0] tab [16];
        tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return tab[v];
    endfunction

    // Expected {anodes, segs} for the counter value and data held before an edge.
    function automatic logic [10:0] expect_out(input logic [3:0] c, input logic [15:0] d, input bit lzb);
        logic [1:0]  s;
        logic [15:0] upper;
        s = c[3:2];
        if (c[1:0] == 2'b00)
            return {4'b1111, 7'h7F};
        upper = d >> (4 * s);
        if (lzb && s != 2'd0 && upper == 16'h0000)
            return {~(4'b0001 << s), 7'h7F};
        return {~(4'b0001 << s), seg_of(upper[3:0])};
    endfunction

    task automatic tick();
        logic [3:0]  c;
        logic [15:0] d;
        logic        r, w;
        logic [15:0] di;
        logic [10:0] e0, e1;
        c  = cnt_m;
        d  = data_m;
        r  = i_rst;
        w  = bus.i_wren;
        di = bus.i_data;
        @(posedge i_clk);
        #1;
        if (r) begin
            e0 = {4'b1111, 7'h7F};
            e1 = {4'b1111, 7'h7F};
            cnt_m  = 4'd0;
            data_m = 16'h0000;
        end else begin
            e0 = expect_out(c, d, 1'b0);
            e1 = expect_out(c, d, 1'b1);
            cnt_m = c + 4'd1;
            if (w)
                data_m = di;
        end
        checkOutput("model_lzb0", 16'({anodes0, segs0}), 16'(e0));
        checkOutput("model_lzb1", 16'({anodes1, segs1}), 16'(e1));
    endtask

    task automatic applyStimulus(input logic [15:0] value);
        bus.i_wren = 1'b1;
        bus.i_data = value;
        tick();
        bus.i_wren = 1'b0;
        bus.i_data = 'x;
    endtask

    function automatic int digit_of(input logic [3:0] an);
        case (an)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    initial begin
        int lit [4];
        int dead_n;
        int prev;
        int dg;
        bit found;
        logic [6:0] want0 [4];
        logic [6:0] want1 [4];

        vec_count  = 0;
        miss_count = 0;
        cnt_m      = 4'd0;
        data_m     = 16'h0000;
        i_rst      = 1'b1;
        bus.i_wren = 1'b0;
        bus.i_data = 16'h0000;

        // Reset, then the first dead and first lit cycles.
        tick();
        tick();
        checkOutput("rst_anodes", 16'(anodes0), 16'h000F);
        checkOutput("rst_segs", 16'(segs0), 16'h007F);
        i_rst = 1'b0;
        tick();
        checkOutput("first_dead_an", 16'(anodes0), 16'h000F);
        checkOutput("first_dead_seg", 16'(segs0), 16'h007F);
        tick();
        checkOutput("first_lit_an", 16'(anodes0), 16'h000E);
        checkOutput("first_lit_seg", 16'(segs0), 16'h0040);

        // 0x1234 over a full period: each digit lit three cycles, four dead cycles.
        applyStimulus(16'h1234);
        want0 = '{7'h19, 7'h30, 7'h24, 7'h79};
        lit = '{0, 0, 0, 0};
        dead_n = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            dg = digit_of(anodes0);
            if (anodes0 == 4'b1111) begin
                dead_n++;
                checkOutput("p1234_dead_seg", 16'(segs0), 16'h007F);
            end else if (dg >= 0) begin
                lit[dg]++;
                checkOutput("p1234_seg", 16'(segs0), 16'(want0[dg]));
            end else begin
                checkOutput("p1234_anodes", 16'(anodes0), 16'h000E);
            end
        end
        for (int k = 0; k < 4; k++)
            checkOutput("p1234_lit_cnt", 16'(lit[k]), 16'd3);
        checkOutput("p1234_dead_cnt", 16'(dead_n), 16'd4);

        // 0xABCD, then idle with unknown data for two periods.
        applyStimulus(16'hABCD);
        want0 = '{7'h21, 7'h46, 7'h03, 7'h08};
        for (int i = 0; i < 32; i++) begin
            tick();
            checkOutput("abcd_no_x", 16'($isunknown({anodes0, segs0, anodes1, segs1})), 16'd0);
            dg = digit_of(anodes0);
            if (dg >= 0)
                checkOutput("abcd_seg", 16'(segs0), 16'(want0[dg]));
        end

        // Leading-zero blanking on the LZB=1 instance.
        applyStimulus(16'h00F0);
        want1 = '{7'h40, 7'h0E, 7'h7F, 7'h7F};
        for (int i = 0; i < 16; i++) begin
            tick();
            dg = digit_of(anodes1);
            if (dg >= 0)
                checkOutput("lzb_00f0_seg", 16'(segs1), 16'(want1[dg]));
        end
        applyStimulus(16'h0000);
        want1 = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
        lit = '{0, 0, 0, 0};
        for (int i = 0; i < 16; i++) begin
            tick();
            dg = digit_of(anodes1);
            if (dg >= 0) begin
                lit[dg]++;
                checkOutput("lzb_0000_seg", 16'(segs1), 16'(want1[dg]));
            end
        end
        checkOutput("lzb_0000_d3_lit", 16'(lit[3]), 16'd3);

        // Reset wins over a simultaneous write.
        applyStimulus(16'h1234);
        i_rst = 1'b1;
        bus.i_wren = 1'b1;
        bus.i_data = 16'hFFFF;
        tick();
        i_rst = 1'b0;
        bus.i_wren = 1'b0;
        bus.i_data = 'x;
        tick();
        tick();
        checkOutput("rst_wins_an", 16'(anodes0), 16'h000E);
        checkOutput("rst_wins_seg", 16'(segs0), 16'h0040);

        // A write during digit 2's slot shows on digit 2 one cycle later.
        found = 1'b0;
        for (int i = 0; i < 32 && !found; i++) begin
            tick();
            if (anodes0 == 4'b1011)
                found = 1'b1;
        end
        checkOutput("wait_digit2", 16'(found), 16'd1);
        applyStimulus(16'h0500);
        checkOutput("mid_old_an", 16'(anodes0), 16'h000B);
        checkOutput("mid_old_seg", 16'(segs0), 16'h0040);
        tick();
        checkOutput("mid_new_an", 16'(anodes0), 16'h000B);
        checkOutput("mid_new_seg", 16'(segs0), 16'h0012);

        // Three full periods: scan order and one-hot-low anodes.
        prev = -1;
        dead_n = 0;
        for (int i = 0; i < 48; i++) begin
            tick();
            if (anodes0 == 4'b1111) begin
                dead_n++;
            end else begin
                checkOutput("onehot", 16'($countones(~anodes0)), 16'd1);
                dg = digit_of(anodes0);
                if (prev >= 0 && dg != prev)
                    checkOutput("scan_order", 16'(dg), 16'((prev + 1) % 4));
                prev = dg;
            end
        end
        checkOutput("wrap_dead_cnt", 16'(dead_n), 16'd12);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
